// File: rtl/cov_signal_tracker_if.sv
// Bundle of sampling, random-read and snapshot-dump signals for cov_signal_tracker.
// The harness side uses the master modport and the tracker uses the slave modport.
interface cov_signal_tracker_if #(
  parameter int N_SIGNALS = 64,
  parameter int CNT_W     = 8,
  parameter int IDX_W     = $clog2(N_SIGNALS),
  parameter int CCNT_W    = $clog2(N_SIGNALS + 1)
);
  logic                 en;
  logic [N_SIGNALS-1:0] sig;
  logic                 clear;

  logic                 rd_req;
  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_ack;
  logic                 rd_err;
  logic                 rd_seen0;
  logic                 rd_seen1;
  logic [CNT_W-1:0]     rd_count;

  logic                 dump_start;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [IDX_W-1:0]     dump_idx;
  logic                 dump_seen0;
  logic                 dump_seen1;
  logic [CNT_W-1:0]     dump_count;
  logic                 dump_done;

  logic                 new_cov;
  logic [CCNT_W-1:0]    covered_count;
  logic                 all_covered;

  modport master (
    output en, sig, clear, rd_req, rd_idx, dump_start, dump_ready,
    input  rd_ack, rd_err, rd_seen0, rd_seen1, rd_count,
    input  dump_valid, dump_idx, dump_seen0, dump_seen1, dump_count, dump_done,
    input  new_cov, covered_count, all_covered
  );

  modport slave (
    input  en, sig, clear, rd_req, rd_idx, dump_start, dump_ready,
    output rd_ack, rd_err, rd_seen0, rd_seen1, rd_count,
    output dump_valid, dump_idx, dump_seen0, dump_seen1, dump_count, dump_done,
    output new_cov, covered_count, all_covered
  );
endinterface

// File: rtl/cov_signal_tracker.sv
// Per-signal seen0/seen1 coverage tracker with random read and handshaked snapshot dump.
// Optional feature macro: COV_HIT_COUNT_EN adds a saturating per-signal hit counter.
module cov_signal_tracker #(
  parameter int N_SIGNALS = 64,
  parameter int CNT_W     = 8,
  parameter int IDX_W     = $clog2(N_SIGNALS),
  parameter int CCNT_W    = $clog2(N_SIGNALS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  cov_signal_tracker_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DUMP = 1'b1;
  localparam int         SEL_W   = $clog2(N_SIGNALS);

  logic [0:0]           state_reg;
  logic [N_SIGNALS-1:0] seen0_reg;
  logic [N_SIGNALS-1:0] seen1_reg;
  logic [CCNT_W-1:0]    covered_count_reg;
  logic                 new_cov_reg;
  logic [IDX_W-1:0]     dump_idx_reg;
  logic                 dump_done_reg;
  logic                 rd_ack_reg;
  logic                 rd_err_reg;
  logic                 rd_seen0_reg;
  logic                 rd_seen1_reg;

  logic                 in_idle;
  logic                 do_clear;
  logic                 do_sample;
  logic                 do_dump_start;
  logic                 dump_accept;
  logic                 dump_last;
  logic                 rd_in_range;
  logic [SEL_W-1:0]     rd_sel;
  logic [SEL_W-1:0]     dump_sel;
  logic [N_SIGNALS-1:0] seen0_next;
  logic [N_SIGNALS-1:0] seen1_next;
  logic [N_SIGNALS-1:0] newly_covered;
  logic [CCNT_W-1:0]    newly_count;

  // clear outranks both sampling and dump_start; everything is frozen outside IDLE
  assign in_idle       = (state_reg == ST_IDLE);
  assign do_clear      = in_idle && bus.clear;
  assign do_dump_start = in_idle && !bus.clear && bus.dump_start;
  assign do_sample     = in_idle && bus.en && !bus.clear && !bus.dump_start;
  assign dump_accept   = (state_reg == ST_DUMP) && bus.dump_ready;
  assign dump_last     = (32'(dump_idx_reg) == N_SIGNALS - 1);
  assign rd_in_range   = (32'(bus.rd_idx) < N_SIGNALS);
  assign rd_sel        = bus.rd_idx[SEL_W-1:0];
  assign dump_sel      = dump_idx_reg[SEL_W-1:0];

  assign seen0_next = seen0_reg | ~bus.sig;
  assign seen1_next = seen1_reg | bus.sig;

  always_comb begin
    newly_covered = seen0_next & seen1_next & ~(seen0_reg & seen1_reg);
    newly_count   = '0;
    for (int i = 0; i < N_SIGNALS; i++) begin
      newly_count = newly_count + CCNT_W'(newly_covered[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      seen0_reg         <= '0;
      seen1_reg         <= '0;
      covered_count_reg <= '0;
      new_cov_reg       <= 1'b0;
      dump_idx_reg      <= '0;
      dump_done_reg     <= 1'b0;
    end else begin
      new_cov_reg   <= 1'b0;
      dump_done_reg <= 1'b0;
      if (do_clear) begin
        seen0_reg         <= '0;
        seen1_reg         <= '0;
        covered_count_reg <= '0;
      end else if (do_sample) begin
        seen0_reg         <= seen0_next;
        seen1_reg         <= seen1_next;
        covered_count_reg <= covered_count_reg + newly_count;
        new_cov_reg       <= (seen0_next != seen0_reg) || (seen1_next != seen1_reg);
      end
      if (do_dump_start) begin
        state_reg    <= ST_DUMP;
        dump_idx_reg <= '0;
      end else if (dump_accept) begin
        if (dump_last) begin
          state_reg     <= ST_IDLE;
          dump_idx_reg  <= '0;
          dump_done_reg <= 1'b1;
        end else begin
          dump_idx_reg <= dump_idx_reg + 1'b1;
        end
      end
    end
  end

  // Read data captures the state before any update at the request edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ack_reg   <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_seen0_reg <= 1'b0;
      rd_seen1_reg <= 1'b0;
    end else begin
      rd_ack_reg   <= bus.rd_req;
      rd_err_reg   <= bus.rd_req && !rd_in_range;
      rd_seen0_reg <= bus.rd_req && rd_in_range && seen0_reg[rd_sel];
      rd_seen1_reg <= bus.rd_req && rd_in_range && seen1_reg[rd_sel];
    end
  end

`ifdef COV_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt_vals [N_SIGNALS];
  logic [CNT_W-1:0] rd_count_reg;

  for (genvar gi = 0; gi < N_SIGNALS; gi++) begin : g_hit_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (do_clear) begin
        cnt_reg <= '0;
      end else if (do_sample && bus.sig[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign cnt_vals[gi] = cnt_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count_reg <= '0;
    end else begin
      rd_count_reg <= (bus.rd_req && rd_in_range) ? cnt_vals[rd_sel] : '0;
    end
  end

  assign bus.rd_count   = rd_count_reg;
  assign bus.dump_count = cnt_vals[dump_sel];
`else
  assign bus.rd_count   = '0;
  assign bus.dump_count = '0;
`endif

  assign bus.rd_ack        = rd_ack_reg;
  assign bus.rd_err        = rd_err_reg;
  assign bus.rd_seen0      = rd_seen0_reg;
  assign bus.rd_seen1      = rd_seen1_reg;
  assign bus.dump_valid    = (state_reg == ST_DUMP);
  assign bus.dump_idx      = dump_idx_reg;
  assign bus.dump_seen0    = seen0_reg[dump_sel];
  assign bus.dump_seen1    = seen1_reg[dump_sel];
  assign bus.dump_done     = dump_done_reg;
  assign bus.new_cov       = new_cov_reg;
  assign bus.covered_count = covered_count_reg;
  assign bus.all_covered   = (32'(covered_count_reg) == N_SIGNALS);
endmodule

// File: tb/tb_cov_signal_tracker.sv
// Directed bench for cov_signal_tracker: 64 signals, 7-bit index, 4-bit hit counters.
// Hit-count expectations depend on whether COV_HIT_COUNT_EN is defined for the build.
module tb_cov_signal_tracker;
  localparam int N = 64;
  localparam int CW = 4;
  localparam int IW = 7;
  localparam int CCW = 7;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  cov_signal_tracker_if #(.N_SIGNALS(N), .CNT_W(CW), .IDX_W(IW), .CCNT_W(CCW)) bus ();

  cov_signal_tracker #(.N_SIGNALS(N), .CNT_W(CW), .IDX_W(IW), .CCNT_W(CCW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic rd(input int idx);
    bus.rd_req = 1'b1;
    bus.rd_idx = IW'(idx);
    tick();
    bus.rd_req = 1'b0;
  endtask

  logic [63:0] pat_a;
  logic [63:0] pat_b;
  logic [63:0] exp_s0;
  logic [63:0] exp_s1;
  int          exp_idx;
  int          exp_cnt10;
  int          exp_cnt20;
  bit          done;
  bit          saw_new_cov;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.sig = '0;
    bus.clear = 1'b0;
    bus.rd_req = 1'b0;
    bus.rd_idx = '0;
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;
`ifdef COV_HIT_COUNT_EN
    exp_cnt10 = 10;
    exp_cnt20 = 15;
`else
    exp_cnt10 = 0;
    exp_cnt20 = 0;
`endif

    // T1: reset values, then one all-zero and one all-one sample
    #12;
    chk("rst_covered", 64'(bus.covered_count), 0);
    chk("rst_new_cov", 64'(bus.new_cov), 0);
    chk("rst_dump_valid", 64'(bus.dump_valid), 0);
    chk("rst_dump_idx", 64'(bus.dump_idx), 0);
    chk("rst_rd_ack", 64'(bus.rd_ack), 0);
    chk("rst_all_cov", 64'(bus.all_covered), 0);
    reset = 1'b0;
    tick();
    bus.en = 1'b1;
    bus.sig = '0;
    tick();
    chk("t1_new_cov0", 64'(bus.new_cov), 1);
    chk("t1_cov0", 64'(bus.covered_count), 0);
    bus.sig = '1;
    tick();
    chk("t1_new_cov1", 64'(bus.new_cov), 1);
    chk("t1_cov64", 64'(bus.covered_count), 64);
    chk("t1_all_cov", 64'(bus.all_covered), 1);
    bus.en = 1'b0;
    tick();
    chk("t1_new_cov_end", 64'(bus.new_cov), 0);

    // T2: sampling disabled
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.sig = (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      tick();
      chk("t2_new_cov", 64'(bus.new_cov), 0);
    end
    chk("t2_cov", 64'(bus.covered_count), 0);
    rd(3);
    chk("t2_rd_seen0", 64'(bus.rd_seen0), 0);
    chk("t2_rd_seen1", 64'(bus.rd_seen1), 0);

    // T3: sig[5] alternates, random read incl. out-of-range
    bus.en = 1'b1;
    bus.sig = '0;
    tick();
    bus.sig = 64'h20;
    bus.rd_req = 1'b1;
    bus.rd_idx = 7'd5;
    tick();
    bus.rd_req = 1'b0;
    chk("t3_rd_old_seen1", 64'(bus.rd_seen1), 0);
    chk("t3_rd_old_seen0", 64'(bus.rd_seen0), 1);
    chk("t3_new_cov", 64'(bus.new_cov), 1);
    chk("t3_cov1", 64'(bus.covered_count), 1);
    bus.en = 1'b0;
    rd(5);
    chk("t3_rd5_ack", 64'(bus.rd_ack), 1);
    chk("t3_rd5_err", 64'(bus.rd_err), 0);
    chk("t3_rd5_seen0", 64'(bus.rd_seen0), 1);
    chk("t3_rd5_seen1", 64'(bus.rd_seen1), 1);
    rd(6);
    chk("t3_rd6_seen0", 64'(bus.rd_seen0), 1);
    chk("t3_rd6_seen1", 64'(bus.rd_seen1), 0);
    rd(70);
    chk("t3_rd70_ack", 64'(bus.rd_ack), 1);
    chk("t3_rd70_err", 64'(bus.rd_err), 1);
    chk("t3_rd70_seen0", 64'(bus.rd_seen0), 0);
    chk("t3_rd70_seen1", 64'(bus.rd_seen1), 0);
    tick();
    chk("t3_rd_ack_drop", 64'(bus.rd_ack), 0);
    chk("t3_rd_err_drop", 64'(bus.rd_err), 0);

    // T4: dump of a frozen snapshot with a stalling consumer
    do_reset();
    pat_a = 64'hFF00_FF00_FF00_FF00;
    pat_b = 64'h0000_0000_FFFF_FFFF;
    exp_s1 = pat_a | pat_b;
    exp_s0 = ~pat_a | ~pat_b;
    bus.en = 1'b1;
    bus.sig = pat_a;
    tick();
    bus.sig = pat_b;
    tick();
    chk("t4_cov32", 64'(bus.covered_count), 32);
    bus.dump_start = 1'b1;
    tick();
    chk("t4_dump_valid", 64'(bus.dump_valid), 1);
    chk("t4_dump_idx0", 64'(bus.dump_idx), 0);
    exp_idx = 0;
    done = 1'b0;
    saw_new_cov = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (bus.dump_valid !== 1'b1 || bus.dump_idx !== IW'(exp_idx) ||
          bus.dump_seen0 !== exp_s0[exp_idx] || bus.dump_seen1 !== exp_s1[exp_idx]) begin
        chk("t4_entry_idx", 64'(bus.dump_idx), 64'(exp_idx));
        chk("t4_entry_s0", 64'(bus.dump_seen0), 64'(exp_s0[exp_idx]));
        chk("t4_entry_s1", 64'(bus.dump_seen1), 64'(exp_s1[exp_idx]));
        chk("t4_entry_valid", 64'(bus.dump_valid), 1);
      end
      if (bus.new_cov === 1'b1 || bus.dump_done === 1'b1) saw_new_cov = 1'b1;
      bus.dump_ready = (cyc % 2 == 1);
      bus.dump_start = (cyc == 9);
      bus.clear = (cyc == 5);
      bus.sig = {$urandom, $urandom};
      tick();
      if (bus.dump_ready) begin
        if (exp_idx == N - 1) done = 1'b1;
        else exp_idx++;
      end
    end
    bus.dump_ready = 1'b0;
    bus.clear = 1'b0;
    bus.en = 1'b0;
    chk("t4_finished", 64'(done), 1);
    chk("t4_no_pulse_in_dump", 64'(saw_new_cov), 0);
    chk("t4_dump_done", 64'(bus.dump_done), 1);
    chk("t4_valid_low", 64'(bus.dump_valid), 0);
    chk("t4_idx_back0", 64'(bus.dump_idx), 0);
    chk("t4_new_cov", 64'(bus.new_cov), 0);
    chk("t4_cov_kept", 64'(bus.covered_count), 32);
    tick();
    chk("t4_done_pulse", 64'(bus.dump_done), 0);

    // T5: hit counter saturation, clear priority
    do_reset();
    bus.en = 1'b1;
    bus.sig = 64'h0;
    tick();
    bus.sig = 64'h1;
    tick();
    chk("t5_new_cov_first", 64'(bus.new_cov), 1);
    tick();
    chk("t5_new_cov_repeat", 64'(bus.new_cov), 0);
    for (int i = 0; i < 8; i++) tick();
    bus.en = 1'b0;
    rd(0);
    chk("t5_cnt10", 64'(bus.rd_count), 64'(exp_cnt10));
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.en = 1'b0;
    rd(0);
    chk("t5_cnt_sat", 64'(bus.rd_count), 64'(exp_cnt20));
    chk("t5_cov1", 64'(bus.covered_count), 1);
    rd(1);
    chk("t5_cnt_idx1", 64'(bus.rd_count), 0);
    bus.clear = 1'b1;
    bus.dump_start = 1'b1;
    bus.en = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.dump_start = 1'b0;
    bus.en = 1'b0;
    chk("t5_clear_no_dump", 64'(bus.dump_valid), 0);
    chk("t5_clear_cov", 64'(bus.covered_count), 0);
    chk("t5_clear_new_cov", 64'(bus.new_cov), 0);
    rd(0);
    chk("t5_clear_cnt", 64'(bus.rd_count), 0);
    chk("t5_clear_seen1", 64'(bus.rd_seen1), 0);
    chk("t5_clear_seen0", 64'(bus.rd_seen0), 0);

    // T6: reset in the middle of a dump
    do_reset();
    bus.en = 1'b1;
    bus.sig = '0;
    tick();
    bus.sig = '1;
    tick();
    bus.en = 1'b0;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.dump_ready = 1'b0;
    chk("t6_idx10", 64'(bus.dump_idx), 10);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.dump_valid), 0);
    chk("t6_rst_idx", 64'(bus.dump_idx), 0);
    chk("t6_rst_cov", 64'(bus.covered_count), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_no_done", 64'(bus.dump_done), 0);
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (bus.dump_idx !== IW'(i) || bus.dump_seen0 !== 1'b0 || bus.dump_seen1 !== 1'b0 ||
          bus.dump_valid !== 1'b1 || bus.dump_done !== 1'b0) begin
        chk("t6_entry_idx", 64'(bus.dump_idx), 64'(i));
        chk("t6_entry_s0", 64'(bus.dump_seen0), 0);
        chk("t6_entry_s1", 64'(bus.dump_seen1), 0);
        chk("t6_entry_valid", 64'(bus.dump_valid), 1);
        chk("t6_entry_done", 64'(bus.dump_done), 0);
      end
      tick();
    end
    bus.dump_ready = 1'b0;
    chk("t6_dump_done", 64'(bus.dump_done), 1);
    chk("t6_valid_low", 64'(bus.dump_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
